// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch unit and its neighbours.
// Optional build macro used by this slice: FETCH_BREAKPOINT_EN.
package cpu_pkg;

    // Sequencer states of the fetch unit.
    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } fetch_state_t;

    // Opcode presented to the control unit whenever nothing executes;
    // it decodes to "no register writes".
    localparam logic [7:0] NOP_OPCODE = 8'h00;

    // Upper nibble of the jump instruction; low nibble is the target.
    localparam logic [3:0] JMP_UPPER = 4'b0001;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: sequencer controls, program-store write port,
// control-unit feedback and the fetch outputs.
// With FETCH_BREAKPOINT_EN defined, bp_en / bp_addr are added.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              run;
    logic              step;
    logic              halt;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ack;
    logic              PC_sel_CU;
    logic              write_pc_CU;
    logic [DATA_W-1:0] opcode;
    logic [ADDR_W-1:0] pc;
    logic              exec_en;
    logic              halted;
`ifdef FETCH_BREAKPOINT_EN
    logic              bp_en;
    logic [ADDR_W-1:0] bp_addr;
`endif

    // Driver side: host/control unit.
    modport master (
        output run, step, halt, prog_we, prog_addr, prog_data,
        output PC_sel_CU, write_pc_CU,
        input  prog_ack, opcode, pc, exec_en, halted
`ifdef FETCH_BREAKPOINT_EN
        , output bp_en, bp_addr
`endif
    );

    // Fetch-unit side.
    modport slave (
        input  run, step, halt, prog_we, prog_addr, prog_data,
        input  PC_sel_CU, write_pc_CU,
        output prog_ack, opcode, pc, exec_en, halted
`ifdef FETCH_BREAKPOINT_EN
        , input bp_en, bp_addr
`endif
    );

endinterface

// File: rtl/prog_store.sv
// Program store: register array with one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module prog_store #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port: word lands at the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, program store and the
// run/step/halt sequencer feeding the control unit.
// Optional macro FETCH_BREAKPOINT_EN adds a single PC breakpoint.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.slave  bus
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic              exec_en;
    logic              in_halt;
    logic              store_we;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] jump_target;
    logic              bp_hit;

    assign in_halt  = (state_q == HALT);
    // Programming is only accepted while stopped; the ack is combinational.
    assign store_we = in_halt && bus.prog_we;

    prog_store #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_prog_store (
        .clk   (clk),
        .we    (store_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (pc_q),
        .rdata (rd_data)
    );

`ifdef FETCH_BREAKPOINT_EN
    logic resume_q;

    // Marks the first RUN cycle after HALT so run can resume from a breakpoint.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resume_q <= 1'b0;
        end else begin
            resume_q <= in_halt;
        end
    end

    assign bp_hit = (state_q == RUN) && bus.bp_en && !resume_q
                    && (pc_q == bus.bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HALT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and execute enable; halt beats run, run beats step.
    always_comb begin
        state_d = state_q;
        exec_en = 1'b0;
        case (state_q)
            HALT: begin
                if (bus.halt) begin
                    state_d = HALT;
                end else if (bus.run) begin
                    state_d = RUN;
                end else if (bus.step) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (bp_hit) begin
                    // Stop in front of the breakpoint instruction.
                    state_d = HALT;
                end else begin
                    exec_en = 1'b1;
                    if (bus.halt) begin
                        state_d = HALT;
                    end
                end
            end
            STEP: begin
                exec_en = 1'b1;
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // Jump target is the low nibble of the instruction, zero-extended.
    assign jump_target = ADDR_W'(rd_data[3:0]);

    // Program counter: moves only when an instruction executes and the
    // control unit asks for it; sequential increment wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else if (exec_en && bus.write_pc_CU) begin
            if (bus.PC_sel_CU) begin
                pc_q <= jump_target;
            end else begin
                pc_q <= pc_q + 1'b1;
            end
        end
    end

    assign bus.opcode   = exec_en ? rd_data : DATA_W'(NOP_OPCODE);
    assign bus.pc       = pc_q;
    assign bus.exec_en  = exec_en;
    assign bus.halted   = in_halt;
    assign bus.prog_ack = store_we;

endmodule
